// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port, byte-addressed data memory between two requesters:
// port 0 (core load/store unit) and port 1 (DMA/debug master). One request is
// captured in IDLE, presented to the memory for one ACCESS cycle (where a
// legal write commits), and completed in RESP with a one-cycle ack, an error
// flag and a size-extended load result.
//
// Timing: IDLE (sample req) -> ACCESS (memory drive) -> RESP (ack).
// The ack appears two cycles after the sampling IDLE cycle, so the block
// sustains one access every three cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN/addrN/wdataN/weN/sizeN   request N (held until ackN)
//   ackN/errN/rdataN         completion pulse, reject flag, load data
//   mem_addr/mem_data        memory address / write data
//   mem_write_sel            memory access size (size[1:0] zero-extended)
//   mem_write                memory write enable (ACCESS cycle only)
//   mem_out                  memory registered read data
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                            between the ports (port 0 first after reset);
//                            otherwise port 0 has fixed priority.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH = 16384,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  input  logic          we0,
  input  logic [2:0]    size0,
  output logic          ack0,
  output logic          err0,
  output logic [31:0]   rdata0,

  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  input  logic          we1,
  input  logic [2:0]    size1,
  output logic          ack1,
  output logic          err1,
  output logic [31:0]   rdata1,

  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic [2:0]    mem_write_sel,
  output logic          mem_write,
  input  logic [31:0]   mem_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Highest legal byte address, widened so address + length cannot wrap.
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

  state_t        state_q, state_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic          legal_q, legal_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;

  // Request selection and legality of the selected request.
  logic          grant;
  logic [AW-1:0] sel_addr;
  logic [2:0]    sel_size;
  logic [AW:0]   nbytes;
  logic [AW:0]   end_addr;
  logic          size_ok;
  logic          sel_legal;

  // Response path.
  logic          resp;
  logic [31:0]   ext_val;
  logic [31:0]   load_val;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic          last_grant_q, last_grant_d;

  // On contention, serve the port that did not win last time.
  always_comb begin
    if (req0 && req1) begin
      grant = ~last_grant_q;
    end else begin
      grant = ~req0;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it requests.
  always_comb begin
    grant = ~req0;
  end
`endif

  always_comb begin
    sel_addr = grant ? addr1 : addr0;
    sel_size = grant ? size1 : size0;

    case (sel_size[1:0])
      2'b00:   nbytes = (AW+1)'(1);
      2'b01:   nbytes = (AW+1)'(2);
      default: nbytes = (AW+1)'(4);
    endcase

    // One extra bit so an access running past the top of the address space
    // lands above LAST_ADDR instead of wrapping to a small address.
    end_addr  = {1'b0, sel_addr} + nbytes - (AW+1)'(1);
    size_ok   = !(sel_size inside {3'b011, 3'b110, 3'b111});
    sel_legal = size_ok && (end_addr <= LAST_ADDR);
  end

  // Load extension of the memory word for the captured size.
  always_comb begin
    case (size_q)
      3'b000:  ext_val = {{24{mem_out[7]}}, mem_out[7:0]};
      3'b001:  ext_val = {{16{mem_out[15]}}, mem_out[15:0]};
      3'b010:  ext_val = mem_out;
      3'b100:  ext_val = {24'd0, mem_out[7:0]};
      3'b101:  ext_val = {16'd0, mem_out[15:0]};
      default: ext_val = 32'd0;
    endcase
    load_val = (!we_q && legal_q) ? ext_val : 32'd0;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    size_d   = size_q;
    legal_d  = legal_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          port_d  = grant;
          we_d    = grant ? we1 : we0;
          size_d  = sel_size;
          legal_d = sel_legal;
          addr_d  = sel_addr;
          wdata_d = grant ? wdata1 : wdata0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_grant_d = grant;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        // Capture the result so it stays visible until the port's next ack.
        if (!port_q) begin
          rdata0_d = load_val;
        end else begin
          rdata1_d = load_val;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 3'd0;
      legal_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      size_q   <= size_d;
      legal_q  <= legal_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Outputs. The write enable is decoded from the state so it can never be
  // high outside ACCESS; ack/err are decoded from RESP for the same reason.
  assign resp          = (state_q == RESP);
  assign ack0          = resp && !port_q;
  assign ack1          = resp && port_q;
  assign err0          = ack0 && !legal_q;
  assign err1          = ack1 && !legal_q;
  // During the ack cycle the fresh load result is passed straight through.
  assign rdata0        = ack0 ? load_val : rdata0_q;
  assign rdata1        = ack1 ? load_val : rdata1_q;

  assign mem_addr      = addr_q;
  assign mem_data      = wdata_q;
  assign mem_write_sel = {1'b0, size_q[1:0]};
  assign mem_write     = (state_q == ACCESS) && we_q && legal_q;

endmodule
